// File: rtl/fft_pkg.sv
// Shared types and helpers for the fft_engine input stage.
package fft_pkg;

   localparam int unsigned FFT_DATA_W = 8;
   localparam int unsigned N_PTS      = 4;

   typedef struct packed {
      logic signed [FFT_DATA_W-1:0] re;
      logic signed [FFT_DATA_W-1:0] im;
   } cplx_t;

   typedef cplx_t frame_t [N_PTS];

   // Number of banks currently holding a complete, unreleased frame.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_BOTH  = 2'd2
   } occ_t;

   // Swap the two index bits: 0,1,2,3 -> 0,2,1,3.
   function automatic logic [1:0] bitrev2(input logic [1:0] idx);
      return {idx[0], idx[1]};
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 4-slot complex sample bank: single write port addressed by slot,
// all slots readable in parallel.
module fft_frame_bank #(
   parameter int unsigned DATA_W = fft_pkg::FFT_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [1:0]               wr_slot,
   input  logic signed [DATA_W-1:0] wr_re,
   input  logic signed [DATA_W-1:0] wr_im,
   output logic signed [DATA_W-1:0] rd_re [fft_pkg::N_PTS],
   output logic signed [DATA_W-1:0] rd_im [fft_pkg::N_PTS]
);
   import fft_pkg::*;

   logic signed [DATA_W-1:0] re_q [N_PTS];
   logic signed [DATA_W-1:0] re_d [N_PTS];
   logic signed [DATA_W-1:0] im_q [N_PTS];
   logic signed [DATA_W-1:0] im_d [N_PTS];

   // Next slot contents: only the addressed slot changes on a write.
   always_comb begin
      re_d = re_q;
      im_d = im_q;
      if (wr_en) begin
         re_d[wr_slot] = wr_re;
         im_d[wr_slot] = wr_im;
      end
   end

   // Slot registers, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_PTS; i++) begin
            re_q[i] <= '0;
            im_q[i] <= '0;
         end
      end else begin
         re_q <= re_d;
         im_q <= im_d;
      end
   end

   assign rd_re = re_q;
   assign rd_im = im_q;

endmodule

// File: rtl/fft_sample_loader.sv
// Serial-to-parallel input stage for fft_engine: collects 4 complex samples
// into one of two banks (ping-pong) and presents a full bank as a frame.
module fft_sample_loader #(
   parameter int unsigned DATA_W      = fft_pkg::FFT_DATA_W,
   parameter bit          BIT_REVERSE = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   input  logic                     in_last,
   output logic                     frame_valid,
   input  logic                     frame_ready,
   output logic signed [DATA_W-1:0] out0_real,
   output logic signed [DATA_W-1:0] out0_imag,
   output logic signed [DATA_W-1:0] out1_real,
   output logic signed [DATA_W-1:0] out1_imag,
   output logic signed [DATA_W-1:0] out2_real,
   output logic signed [DATA_W-1:0] out2_imag,
   output logic signed [DATA_W-1:0] out3_real,
   output logic signed [DATA_W-1:0] out3_imag,
   output logic                     err_short
);
   import fft_pkg::*;

   occ_t       occ_q, occ_d;
   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] wr_idx_q, wr_idx_d;
   logic       in_ready_q, in_ready_d;
   logic       err_short_q, err_short_d;

   logic       accept;
   logic       frame_complete;
   logic       frame_release;
   logic [1:0] wr_slot;

   logic signed [DATA_W-1:0] b0_re [N_PTS];
   logic signed [DATA_W-1:0] b0_im [N_PTS];
   logic signed [DATA_W-1:0] b1_re [N_PTS];
   logic signed [DATA_W-1:0] b1_im [N_PTS];
   logic signed [DATA_W-1:0] sel_re [N_PTS];
   logic signed [DATA_W-1:0] sel_im [N_PTS];

   // Per-bank full flags are implied by occupancy: the read bank is full
   // whenever occupancy is not EMPTY, and the write bank only when BOTH.
   assign frame_valid    = (occ_q != OCC_EMPTY);
   assign in_ready       = in_ready_q;
   assign err_short      = err_short_q;
   assign accept         = in_valid & in_ready_q;
   assign frame_complete = accept & (wr_idx_q == 2'd3);
   assign frame_release  = frame_valid & frame_ready;
   assign wr_slot        = BIT_REVERSE ? bitrev2(wr_idx_q) : wr_idx_q;

   fft_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
      .clk     (clk),
      .rst_n   (rst),
      .wr_en   (accept & ~wr_bank_q),
      .wr_slot (wr_slot),
      .wr_re   (in_real),
      .wr_im   (in_imag),
      .rd_re   (b0_re),
      .rd_im   (b0_im)
   );

   fft_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
      .clk     (clk),
      .rst_n   (rst),
      .wr_en   (accept & wr_bank_q),
      .wr_slot (wr_slot),
      .wr_re   (in_real),
      .wr_im   (in_imag),
      .rd_re   (b1_re),
      .rd_im   (b1_im)
   );

   // Occupancy, pointer and error next-state logic.
   always_comb begin
      occ_d       = occ_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_idx_d    = wr_idx_q;
      err_short_d = 1'b0;

      unique case (occ_q)
         OCC_EMPTY: if (frame_complete) occ_d = OCC_ONE;
         OCC_ONE: begin
            if (frame_complete && !frame_release)      occ_d = OCC_BOTH;
            else if (frame_release && !frame_complete) occ_d = OCC_EMPTY;
         end
         OCC_BOTH:  if (frame_release) occ_d = OCC_ONE;
         default:   occ_d = OCC_EMPTY;
      endcase

      if (accept) begin
         if (wr_idx_q == 2'd3) begin
            wr_idx_d  = '0;
            wr_bank_d = ~wr_bank_q;
         end else if (in_last) begin
            wr_idx_d    = '0;
            err_short_d = 1'b1;
         end else begin
            wr_idx_d = wr_idx_q + 2'd1;
         end
      end

      if (frame_release) rd_bank_d = ~rd_bank_q;

      // Registered so in_ready stays low through reset and has no path
      // from frame_ready.
      in_ready_d = (occ_d != OCC_BOTH);
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q       <= OCC_EMPTY;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_idx_q    <= '0;
         in_ready_q  <= 1'b0;
         err_short_q <= 1'b0;
      end else begin
         occ_q       <= occ_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_idx_q    <= wr_idx_d;
         in_ready_q  <= in_ready_d;
         err_short_q <= err_short_d;
      end
   end

   // Present the read bank on the parallel outputs.
   always_comb begin
      for (int unsigned i = 0; i < N_PTS; i++) begin
         sel_re[i] = rd_bank_q ? b1_re[i] : b0_re[i];
         sel_im[i] = rd_bank_q ? b1_im[i] : b0_im[i];
      end
   end

   assign out0_real = sel_re[0];
   assign out0_imag = sel_im[0];
   assign out1_real = sel_re[1];
   assign out1_imag = sel_im[1];
   assign out2_real = sel_re[2];
   assign out2_imag = sel_im[2];
   assign out3_real = sel_re[3];
   assign out3_imag = sel_im[3];

endmodule
